// File: rtl/reg_file_writeback_pkg.sv
// Shared constants for the register-file writeback slice.
// Provides the default data width, register-index geometry, the x0 index,
// and the RV32I writeback-producing opcodes used by the exec units.
package reg_file_writeback_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned REG_COUNT    = 32;

  localparam logic [REG_IDX_W-1:0] X0_IDX = 5'd0;

  // RV32I major opcodes whose result is written back to rd
  localparam logic [6:0] OP_LUI   = 7'b0110111;  // U-type
  localparam logic [6:0] OP_AUIPC = 7'b0010111;  // U-type
  localparam logic [6:0] OP_IMM   = 7'b0010011;  // I-type ALU
  localparam logic [6:0] OP_LOAD  = 7'b0000011;  // I-type load
  localparam logic [6:0] OP_JALR  = 7'b1100111;  // I-type jump
  localparam logic [6:0] OP_JAL   = 7'b1101111;  // J-type jump
  localparam logic [6:0] OP_REG   = 7'b0110011;  // R-type ALU

  // True when the opcode produces a register writeback
  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode == OP_LUI)  || (opcode == OP_AUIPC) || (opcode == OP_IMM) ||
           (opcode == OP_LOAD) || (opcode == OP_JALR)  || (opcode == OP_JAL) ||
           (opcode == OP_REG);
  endfunction

endpackage

// File: rtl/reg_file_writeback_wb_fifo.sv
// In-order writeback FIFO.
// Ports: push/push_idx/push_val enqueue at tail; pop retires the head
// (head_idx/head_val); count/full/empty describe occupancy; age_val and
// q1_match/q2_match present the entries oldest-first (slot 0 = head) with a
// per-entry index match for two query indices.
module reg_file_writeback_wb_fifo
  import reg_file_writeback_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [REG_IDX_W-1:0]           push_idx,
  input  logic [XLEN-1:0]                push_val,
  input  logic                           pop,
  output logic [REG_IDX_W-1:0]           head_idx,
  output logic [XLEN-1:0]                head_val,
  output logic [CNT_W-1:0]               count,
  output logic                           full,
  output logic                           empty,
  input  logic [REG_IDX_W-1:0]           q1_idx,
  input  logic [REG_IDX_W-1:0]           q2_idx,
  output logic [DEPTH-1:0][XLEN-1:0]     age_val,
  output logic [DEPTH-1:0]               q1_match,
  output logic [DEPTH-1:0]               q2_match
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [REG_IDX_W-1:0] ent_idx [DEPTH];
  logic [XLEN-1:0]      ent_val [DEPTH];

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_idx[i] <= '0;
        ent_val[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_idx[wr_ptr] <= push_idx;
        ent_val[wr_ptr] <= push_val;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign head_idx = ent_idx[rd_ptr];
  assign head_val = ent_val[rd_ptr];

  // Age-ordered view: slot k is the k-th oldest pending entry
  always_comb begin
    age_val  = '0;
    q1_match = '0;
    q2_match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_val[k]  = ent_val[rd_ptr + PTR_W'(k)];
      q1_match[k] = (CNT_W'(k) < count) && (ent_idx[rd_ptr + PTR_W'(k)] == q1_idx);
      q2_match[k] = (CNT_W'(k) < count) && (ent_idx[rd_ptr + PTR_W'(k)] == q2_idx);
    end
  end

endmodule

// File: rtl/reg_file_writeback.sv
// Register-file writeback endpoint.
// Ports: reg_w_op/reg_w_reg_idx/reg_w_reg_val carry write requests, accepted
// while wb_ready; drain_en permits retiring the FIFO head into the 32-entry
// register file; rs1/rs2 read ports bypass from pending entries;
// wb_empty/wb_count report occupancy; commit_* report the entry retired on
// the previous edge.
module reg_file_writeback
  import reg_file_writeback_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_w_op,
  input  logic [REG_IDX_W-1:0] reg_w_reg_idx,
  input  logic [XLEN-1:0]      reg_w_reg_val,
  output logic                 wb_ready,
  input  logic                 drain_en,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  output logic [XLEN-1:0]      rs1_val,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs2_val,
  output logic                 wb_empty,
  output logic [CNT_W-1:0]     wb_count,
  output logic                 commit_op,
  output logic [REG_IDX_W-1:0] commit_idx,
  output logic [XLEN-1:0]      commit_val
);

  logic                       full;
  logic                       push;
  logic                       pop;
  logic [REG_IDX_W-1:0]       head_idx;
  logic [XLEN-1:0]            head_val;
  logic [DEPTH-1:0][XLEN-1:0] age_val;
  logic [DEPTH-1:0]           q1_match;
  logic [DEPTH-1:0]           q2_match;
  logic [XLEN-1:0]            regs [REG_COUNT];

  // Writes to x0 are accepted for handshake purposes but never stored
  assign wb_ready = !full;
  assign push     = reg_w_op && !full && (reg_w_reg_idx != X0_IDX);
  assign pop      = drain_en && !wb_empty;

  reg_file_writeback_wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_wb_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (reg_w_reg_idx),
    .push_val (reg_w_reg_val),
    .pop      (pop),
    .head_idx (head_idx),
    .head_val (head_val),
    .count    (wb_count),
    .full     (full),
    .empty    (wb_empty),
    .q1_idx   (rs1_idx),
    .q2_idx   (rs2_idx),
    .age_val  (age_val),
    .q1_match (q1_match),
    .q2_match (q2_match)
  );

  // Architectural register file, written only by retiring entries
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (pop) begin
      regs[head_idx] <= head_val;
    end
  end

  // Commit report; idx/val hold when nothing retires
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_op  <= 1'b0;
      commit_idx <= '0;
      commit_val <= '0;
    end else begin
      commit_op <= pop;
      if (pop) begin
        commit_idx <= head_idx;
        commit_val <= head_val;
      end
    end
  end

  // Youngest matching entry wins: later (younger) slots override earlier ones
  function automatic logic [XLEN-1:0] pick_youngest(
    input logic [DEPTH-1:0]           match,
    input logic [DEPTH-1:0][XLEN-1:0] vals,
    input logic [XLEN-1:0]            dflt
  );
    logic [XLEN-1:0] res;
    res = dflt;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        res = vals[k];
      end
    end
    return res;
  endfunction

  // Read port 1
  always_comb begin
    rs1_val = pick_youngest(q1_match, age_val, regs[rs1_idx]);
    if (rs1_idx == X0_IDX) begin
      rs1_val = '0;
    end
  end

  // Read port 2
  always_comb begin
    rs2_val = pick_youngest(q2_match, age_val, regs[rs2_idx]);
    if (rs2_idx == X0_IDX) begin
      rs2_val = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_writeback.sv
module tb_reg_file_writeback;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned NVEC  = 24;
  localparam int unsigned NRAND = 3000;

  logic             clk;
  logic             rst;
  logic             reg_w_op;
  logic [4:0]       reg_w_reg_idx;
  logic [XLEN-1:0]  reg_w_reg_val;
  logic             wb_ready;
  logic             drain_en;
  logic [4:0]       rs1_idx;
  logic [XLEN-1:0]  rs1_val;
  logic [4:0]       rs2_idx;
  logic [XLEN-1:0]  rs2_val;
  logic             wb_empty;
  logic [CNT_W-1:0] wb_count;
  logic             commit_op;
  logic [4:0]       commit_idx;
  logic [XLEN-1:0]  commit_val;

  reg_file_writeback #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_w_op      (reg_w_op),
    .reg_w_reg_idx (reg_w_reg_idx),
    .reg_w_reg_val (reg_w_reg_val),
    .wb_ready      (wb_ready),
    .drain_en      (drain_en),
    .rs1_idx       (rs1_idx),
    .rs1_val       (rs1_val),
    .rs2_idx       (rs2_idx),
    .rs2_val       (rs2_val),
    .wb_empty      (wb_empty),
    .wb_count      (wb_count),
    .commit_op     (commit_op),
    .commit_idx    (commit_idx),
    .commit_val    (commit_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_regs [32];
  logic        m_cop;
  logic [4:0]  m_cidx;
  logic [31:0] m_cval;

  task automatic m_reset();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cop  = 1'b0;
    m_cidx = '0;
    m_cval = '0;
  endtask

  // One clock edge: decisions use the occupancy seen before the edge
  task automatic m_step(input logic op, input logic [4:0] idx, input logic [31:0] val,
                        input logic drain);
    bit   do_pop;
    bit   acc;
    ent_t e;
    do_pop = drain && (m_q.size() > 0);
    acc    = op && (m_q.size() < DEPTH);
    if (do_pop) begin
      e = m_q.pop_front();
      m_regs[e.idx] = e.val;
      m_cop  = 1'b1;
      m_cidx = e.idx;
      m_cval = e.val;
    end else begin
      m_cop = 1'b0;
    end
    if (acc && idx != 5'd0) begin
      e.idx = idx;
      e.val = val;
      m_q.push_back(e);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].idx == idx) return m_q[i].val;
    end
    return m_regs[idx];
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".wb_count"},   32'(wb_count),   32'(m_q.size()));
    check({tag, ".wb_empty"},   32'(wb_empty),   32'(m_q.size() == 0));
    check({tag, ".wb_ready"},   32'(wb_ready),   32'(m_q.size() < DEPTH));
    check({tag, ".commit_op"},  32'(commit_op),  32'(m_cop));
    check({tag, ".commit_idx"}, 32'(commit_idx), 32'(m_cidx));
    check({tag, ".commit_val"}, commit_val,      m_cval);
    check({tag, ".rs1_val"},    rs1_val,         m_read(rs1_idx));
    check({tag, ".rs2_val"},    rs2_val,         m_read(rs2_idx));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        op;
    logic [4:0]  idx;
    logic [31:0] val;
    logic        drain;
    logic [4:0]  r1;
    logic [4:0]  r2;
    int          cnt;
    logic        rdy;
    logic        cop;
    logic [4:0]  cidx;
    logic [31:0] cval;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [NVEC];

  initial begin
    //            op idx  val           dr  r1  r2  cnt rdy cop cidx  cval          e1            e2
    tbl[0]  = '{1'b1, 5'd5, 32'h12345000, 1'b0, 5'd5, 5'd0, 1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h12345000, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd0, 0, 1'b1, 1'b1, 5'd5, 32'h12345000, 32'h12345000, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 0, 1'b1, 1'b0, 5'd5, 32'h12345000, 32'h12345000, 32'h0};
    tbl[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd5, 0, 1'b1, 1'b0, 5'd5, 32'h12345000, 32'h0,        32'h12345000};
    tbl[4]  = '{1'b1, 5'd1, 32'h11,       1'b0, 5'd1, 5'd2, 1, 1'b1, 1'b0, 5'd5, 32'h12345000, 32'h11,       32'h0};
    tbl[5]  = '{1'b1, 5'd2, 32'h22,       1'b0, 5'd1, 5'd2, 2, 1'b1, 1'b0, 5'd5, 32'h12345000, 32'h11,       32'h22};
    tbl[6]  = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd3, 5'd4, 3, 1'b1, 1'b0, 5'd5, 32'h12345000, 32'h33,       32'h0};
    tbl[7]  = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd4, 5'd9, 4, 1'b0, 1'b0, 5'd5, 32'h12345000, 32'h44,       32'h0};
    tbl[8]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd9, 5'd1, 4, 1'b0, 1'b0, 5'd5, 32'h12345000, 32'h0,        32'h11};
    tbl[9]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd9, 5'd1, 4, 1'b0, 1'b0, 5'd5, 32'h12345000, 32'h0,        32'h11};
    tbl[10] = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd9, 5'd1, 4, 1'b0, 1'b0, 5'd5, 32'h12345000, 32'h0,        32'h11};
    tbl[11] = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 5'd1, 3, 1'b1, 1'b1, 5'd1, 32'h11,       32'h0,        32'h11};
    tbl[12] = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 5'd2, 3, 1'b1, 1'b1, 5'd2, 32'h22,       32'h99,       32'h22};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd3, 3, 1'b1, 1'b0, 5'd2, 32'h22,       32'h99,       32'h33};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd4, 2, 1'b1, 1'b1, 5'd3, 32'h33,       32'h33,       32'h44};
    tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd4, 1, 1'b1, 1'b1, 5'd4, 32'h44,       32'h99,       32'h44};
    tbl[16] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd0, 0, 1'b1, 1'b1, 5'd9, 32'h99,       32'h99,       32'h0};
    tbl[17] = '{1'b1, 5'd7, 32'h1,        1'b0, 5'd7, 5'd0, 1, 1'b1, 1'b0, 5'd9, 32'h99,       32'h1,        32'h0};
    tbl[18] = '{1'b1, 5'd7, 32'h2,        1'b0, 5'd7, 5'd0, 2, 1'b1, 1'b0, 5'd9, 32'h99,       32'h2,        32'h0};
    tbl[19] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 1, 1'b1, 1'b1, 5'd7, 32'h1,        32'h2,        32'h0};
    tbl[20] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 0, 1'b1, 1'b1, 5'd7, 32'h2,        32'h2,        32'h0};
    tbl[21] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd0, 0, 1'b1, 1'b0, 5'd7, 32'h2,        32'h2,        32'h0};
    tbl[22] = '{1'b1, 5'd8, 32'h88,       1'b1, 5'd8, 5'd7, 1, 1'b1, 1'b0, 5'd7, 32'h2,        32'h88,       32'h2};
    tbl[23] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 5'd7, 0, 1'b1, 1'b1, 5'd8, 32'h88,       32'h88,       32'h2};
  end

  // ---------------- main sequence ----------------
  initial begin
    string tag;
    logic  nop;
    logic [4:0]  nidx;
    logic [31:0] nval;
    logic        ndr;

    rst = 1'b1; reg_w_op = 1'b0; reg_w_reg_idx = '0; reg_w_reg_val = '0;
    drain_en = 1'b0; rs1_idx = 5'd5; rs2_idx = 5'd0;
    cyc();
    rst = 1'b0;
    #1;
    check("reset.rs1_val",   rs1_val,          32'h0);
    check("reset.rs2_val",   rs2_val,          32'h0);
    check("reset.wb_empty",  32'(wb_empty),    32'h1);
    check("reset.wb_count",  32'(wb_count),    32'h0);
    check("reset.commit_op", 32'(commit_op),   32'h0);
    check("reset.wb_ready",  32'(wb_ready),    32'h1);

    // Directed table: apply row, clock, compare
    for (int i = 0; i < NVEC; i++) begin
      reg_w_op = tbl[i].op; reg_w_reg_idx = tbl[i].idx; reg_w_reg_val = tbl[i].val;
      drain_en = tbl[i].drain; rs1_idx = tbl[i].r1; rs2_idx = tbl[i].r2;
      cyc();
      tag = $sformatf("vec%0d", i);
      check({tag, ".wb_count"},   32'(wb_count),   32'(tbl[i].cnt));
      check({tag, ".wb_empty"},   32'(wb_empty),   32'(tbl[i].cnt == 0));
      check({tag, ".wb_ready"},   32'(wb_ready),   32'(tbl[i].rdy));
      check({tag, ".commit_op"},  32'(commit_op),  32'(tbl[i].cop));
      check({tag, ".commit_idx"}, 32'(commit_idx), 32'(tbl[i].cidx));
      check({tag, ".commit_val"}, commit_val,      tbl[i].cval);
      check({tag, ".rs1_val"},    rs1_val,         tbl[i].e1);
      check({tag, ".rs2_val"},    rs2_val,         tbl[i].e2);
    end

    // Reset with three pending entries discards them and clears the regfile
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      reg_w_op = 1'b1; reg_w_reg_idx = 5'(10 + i); reg_w_reg_val = 32'hA0 + 32'(i);
      cyc();
    end
    reg_w_op = 1'b0;
    check("prerst.wb_count", 32'(wb_count), 32'h3);
    rst = 1'b1; rs1_idx = 5'd5; rs2_idx = 5'd10;
    cyc();
    rst = 1'b0;
    check("midrst.wb_count",   32'(wb_count),   32'h0);
    check("midrst.wb_empty",   32'(wb_empty),   32'h1);
    check("midrst.commit_op",  32'(commit_op),  32'h0);
    check("midrst.commit_idx", 32'(commit_idx), 32'h0);
    check("midrst.rs1_val",    rs1_val,         32'h0);
    check("midrst.rs2_val",    rs2_val,         32'h0);
    rs1_idx = 5'd7; rs2_idx = 5'd8;
    #1;
    check("midrst.rs1_x7", rs1_val, 32'h0);
    check("midrst.rs2_x8", rs2_val, 32'h0);
    cyc();
    check("midrst.idle_count", 32'(wb_count), 32'h0);

    // Randomized traffic against the reference model
    m_reset();
    for (int n = 0; n < NRAND; n++) begin
      nop  = ($urandom_range(0, 9) < 6);
      nidx = 5'($urandom_range(0, 7));
      nval = $urandom;
      ndr  = ($urandom_range(0, 9) < 5);
      reg_w_op = nop; reg_w_reg_idx = nidx; reg_w_reg_val = nval; drain_en = ndr;
      rs1_idx = 5'($urandom_range(0, 7)); rs2_idx = 5'($urandom_range(0, 7));
      #1;
      // Same-cycle incoming request must not be visible yet
      check("rnd.pre.rs1_val", rs1_val, m_read(rs1_idx));
      check("rnd.pre.rs2_val", rs2_val, m_read(rs2_idx));
      check("rnd.pre.wb_ready", 32'(wb_ready), 32'(m_q.size() < DEPTH));
      m_step(nop, nidx, nval, ndr);
      cyc();
      check_model("rnd.post");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
